prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Downstream stage of the 32x32 multiplier top; consumes its 64-bit unsigned product stream P.
- Sums a frame of products, bounded by LEN beats or an in_last marker, into a wide accumulator.
- Presents each frame's sum to the next stage through a valid/ready handshake.
- Used for dot-product and average checks on multiplier output in the synthesis/Openlane flow.

Parameters:
- PW, 64, product (input) width in bits.
- AW, 72, accumulator and output sum width in bits; must be >= PW.
- LEN, 8, maximum products per frame; range 1..255.
- CW, 8, width of the beat counter and of out_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous frame abort; discards the partial sum.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_p  input  PW  unsigned product (the multiplier's P).
- in_last  input  1  marks the final beat of a frame; qualified by in_valid.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  AW  sum of the frame's products.
- out_count  output  CW  number of beats in the frame (1..LEN).
- out_ovf  output  1  sticky: the frame sum exceeded 2^AW-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to ACC; accumulator and counter go to 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready is 1 on the first edge after reset release.
- States: ACC, HOLD.
- ACC state:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid=1 and in_ready=1.
  - On accept: acc <= acc + zero-extended in_p, computed in AW+1 bits; cnt <= cnt+1.
  - If the carry bit is set, ovf <= 1 and acc keeps the low AW bits (wraps). The wrap is flagged, not saturated.
- ACC -> HOLD happens when the accepted beat has in_last=1, or when cnt+1 == LEN.
  - The registered result (out_sum, out_count, out_ovf) is valid the cycle after the final beat, with out_valid=1. Latency is 1 cycle.
- HOLD state:
  - in_ready=0; out_sum, out_count and out_ovf are held stable while out_valid=1 and out_ready=0.
  - When out_valid and out_ready are both 1: return to ACC; acc, cnt and ovf clear to 0; out_valid drops the next cycle.
  - There is no same-cycle pass-through; in_ready rises the cycle after the handshake.
- The HOLD -> ACC return costs one cycle of bubble between frames. At LEN=1 every beat is a frame and throughput is 1 beat per 2 cycles.
- in_last on a beat that also reaches LEN closes a single frame, not two.
- clr=1 (synchronous, highest priority after reset):
  - In ACC: acc, cnt and ovf go to 0, and any beat presented that cycle is dropped (in_ready stays 1, but the beat is not summed).
  - In HOLD: the pending result is discarded; out_valid goes to 0 and the state returns to ACC.
- in_valid with in_ready=0 is ignored; the source must hold its data (standard valid/ready rule).
- Asynchronous reset asserted mid-frame or during HOLD discards everything immediately. No partial result is ever emitted.
- Width rule: out_count counts beats accepted in the frame. With LEN <= 2^CW-1 it never wraps.

Decomposition:
- Shared package mult_pkg holds:
  - constants PROD_W=64, ACC_W=72, and OP_W=32 (shared with the multiplier top);
  - enum acc_state_t {ACC, HOLD}.
- One natural sub-module: acc_adder, an (AW+1)-bit zero-extend adder returning {carry, sum}. It is isolated so synthesis can retime or replace it.
- Counter and FSM stay in the parent.

Test Plan:
- Reset then frame, LEN=8:
  - Stimulus: rst low 20 ns, then 8 back-to-back beats of P=1..8, out_ready=1.
  - Required: one result with out_sum=36, out_count=8, out_ovf=0, out_valid high exactly 1 cycle, in_ready low only during HOLD.
- Early in_last:
  - Stimulus: beats 0x10, 0x20, 0x30 with in_last on the third.
  - Required: out_sum=0x60, out_count=3; the next frame starts from 0.
- Backpressure:
  - Stimulus: complete a frame with out_ready=0 for 5 cycles, with in_valid held high throughout.
  - Required: out_* stable, in_ready=0, no beats lost.
  - After out_ready=1: the following frame sums correctly.
- Overflow, AW=64 override:
  - Stimulus: beats 0xFFFF_FFFF_FFFF_FFFF and 0x2.
  - Required: out_sum=0x1, out_ovf=1.
  - Next frame: out_ovf=0.
- Clear mid-frame:
  - Stimulus: beats 5 and 7, then clr=1 with in_valid=1 and in_p=9, then beats 2 and 3 with in_last.
  - Required: out_sum=5, out_count=2.
- Async reset in HOLD:
  - Stimulus: drop rst while out_valid=1 and out_ready=0.
  - Required: out_valid=0 and out_sum=0 immediately; no result after reset release.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the multiplier top and its downstream accumulator.
package mult_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned ACC_W  = 72;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

// File: rtl/prod_accumulator_if.sv
// Product stream in, frame result out: valid/ready bundle for the product accumulator.
interface prod_accumulator_if #(
  parameter int unsigned PW = 64,
  parameter int unsigned AW = 72,
  parameter int unsigned CW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_p;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/prod_accumulator_adder.sv
// Zero-extending (AW+1)-bit adder; kept separate so synthesis can retime or swap it.
module acc_adder #(
  parameter int unsigned AW = 72,
  parameter int unsigned PW = 64
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW:0]   sum
);

  assign sum = {1'b0, a} + (AW+1)'(b);

endmodule

// File: rtl/prod_accumulator.sv
// Frame accumulator for the multiplier product stream: sums up to LEN beats (or up to
// in_last) and presents {sum, count, overflow} through a valid/ready handshake.
module prod_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned PW  = PROD_W,
  parameter int unsigned AW  = ACC_W,
  parameter int unsigned LEN = 8,
  parameter int unsigned CW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  prod_accumulator_if.slave    bus
);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic [AW:0]   add_sum;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          frame_end;
  logic          release_out;

  acc_adder #(.AW(AW), .PW(PW)) u_adder (
    .a   (acc_q),
    .b   (bus.in_p),
    .sum (add_sum)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // The result registers are the accumulator itself: frozen in HOLD, so no separate output copy.
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ACC;
    else      state_q <= state_d;
  end

  // Next state and handshake outputs; clr forces ACC from either state.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    frame_end     = 1'b0;
    release_out   = 1'b0;
    unique case (state_q)
      ACC: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid & ~clr;
        frame_end    = accept & (bus.in_last | (cnt_inc == LEN_C));
        if (frame_end) state_d = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        release_out   = bus.out_ready;
        if (bus.out_ready) state_d = ACC;
      end
    endcase
    if (clr) state_d = ACC;
  end

  // Accumulator, beat counter and sticky overflow; cleared on abort or on result handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr || release_out) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= add_sum[AW-1:0];
      cnt_q <= cnt_inc;
      ovf_q <= ovf_q | add_sum[AW];
    end
  end

  // Beat count never passes LEN within a frame.
  always @(posedge clk) begin
    if (rst) assert (cnt_q <= LEN_C);
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: default 72-bit instance plus a 64-bit one for wrap.
module tb_prod_accumulator;
  import mult_pkg::*;

  typedef struct {
    logic [71:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic clr64 = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t sb64[$];

  prod_accumulator_if #(.PW(64), .AW(72), .CW(8)) bus ();
  prod_accumulator_if #(.PW(64), .AW(64), .CW(8)) bus64 ();

  prod_accumulator #(.PW(64), .AW(72), .LEN(8), .CW(8)) dut (
    .clk (clk), .rst (rst), .clr (clr), .bus (bus.slave)
  );

  prod_accumulator #(.PW(64), .AW(64), .LEN(8), .CW(8)) dut64 (
    .clk (clk), .rst (rst), .clr (clr64), .bus (bus64.slave)
  );

  always #5 clk = ~clk;

  task automatic send_beat(input logic [63:0] p, input logic last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_accept: in_ready=%0b required 1 within 20 cycles", bus.in_ready);
    end
  endtask

  task automatic send_beat64(input logic [63:0] p, input logic last);
    bit ok = 1'b0;
    bus64.in_valid = 1'b1;
    bus64.in_p     = p;
    bus64.in_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (bus64.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_accept64: in_ready=%0b required 1 within 20 cycles", bus64.in_ready);
    end
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_result64(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus64.out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 72'h0 || bus.out_count !== 8'h0 || bus.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b sum=%0h count=%0d ovf=%0b required 0/0/0/0",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_full_frame();
    exp_t e, got_e;
    bit ok;
    logic [71:0] s = '0;
    for (int i = 1; i <= 8; i++) s += 72'(i);
    e.sum = s; e.count = 8'd8; e.ovf = 1'b0;
    sb.push_back(e);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_beat(64'(i), 1'b0);
    bus.in_valid = 1'b0;
    wait_result(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL full_frame_valid: out_valid=%0b sb=%0d required result", bus.out_valid, sb.size());
    end else begin
      got_e = sb.pop_front();
      checks++;
      if (bus.out_sum !== got_e.sum || bus.out_count !== got_e.count || bus.out_ovf !== got_e.ovf) begin
        failures++;
        $display("FAIL full_frame_result: sum=%0d count=%0d ovf=%0b required %0d/%0d/%0b",
                 bus.out_sum, bus.out_count, bus.out_ovf, got_e.sum, got_e.count, got_e.ovf);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_in_ready: got %0b required 0", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL valid_one_cycle: out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_early_last();
    exp_t e, got_e;
    bit ok;
    e.sum = 72'h60; e.count = 8'd3; e.ovf = 1'b0;
    sb.push_back(e);
    send_beat(64'h10, 1'b0);
    send_beat(64'h20, 1'b0);
    send_beat(64'h30, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(ok);
    got_e = sb.pop_front();
    checks++;
    if (!ok || bus.out_sum !== got_e.sum || bus.out_count !== got_e.count || bus.out_ovf !== got_e.ovf) begin
      failures++;
      $display("FAIL early_last: valid=%0b sum=%0h count=%0d ovf=%0b required 1/%0h/%0d/%0b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, got_e.sum, got_e.count, got_e.ovf);
    end
    @(negedge clk);
    e.sum = 72'h4; e.count = 8'd1; e.ovf = 1'b0;
    sb.push_back(e);
    send_beat(64'h4, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(ok);
    got_e = sb.pop_front();
    checks++;
    if (!ok || bus.out_sum !== got_e.sum || bus.out_count !== got_e.count) begin
      failures++;
      $display("FAIL early_last_next: sum=%0h count=%0d required %0h/%0d",
               bus.out_sum, bus.out_count, got_e.sum, got_e.count);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e, got_e;
    bit ok;
    logic [71:0] s = '0;
    for (int i = 10; i < 18; i++) s += 72'(i);
    e.sum = s; e.count = 8'd8; e.ovf = 1'b0;
    sb.push_back(e);
    for (int i = 10; i < 18; i++) send_beat(64'(i), (i == 17) ? 1'b1 : 1'b0);
    bus.in_valid = 1'b0;
    wait_result(ok);
    got_e = sb.pop_front();
    checks++;
    if (!ok || bus.out_sum !== got_e.sum || bus.out_count !== got_e.count) begin
      failures++;
      $display("FAIL last_at_len: sum=%0d count=%0d required %0d/%0d",
               bus.out_sum, bus.out_count, got_e.sum, got_e.count);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL last_at_len_single: out_valid=%0b required 0 at cycle %0d", bus.out_valid, i);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e, got_e;
    bit ok;
    e.sum = 72'd600; e.count = 8'd3; e.ovf = 1'b0;
    sb.push_back(e);
    bus.out_ready = 1'b0;
    send_beat(64'd100, 1'b0);
    send_beat(64'd200, 1'b0);
    send_beat(64'd300, 1'b1);
    bus.in_p    = 64'd7;
    bus.in_last = 1'b0;
    got_e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== got_e.sum ||
          bus.out_count !== got_e.count || bus.out_ovf !== got_e.ovf) begin
        failures++;
        $display("FAIL backpressure_hold: valid=%0b ready=%0b sum=%0d count=%0d required 1/0/%0d/%0d",
                 bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count, got_e.sum, got_e.count);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    e.sum = 72'd15; e.count = 8'd2; e.ovf = 1'b0;
    sb.push_back(e);
    send_beat(64'd7, 1'b0);
    send_beat(64'd8, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(ok);
    got_e = sb.pop_front();
    checks++;
    if (!ok || bus.out_sum !== got_e.sum || bus.out_count !== got_e.count) begin
      failures++;
      $display("FAIL backpressure_next: sum=%0d count=%0d required %0d/%0d",
               bus.out_sum, bus.out_count, got_e.sum, got_e.count);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    exp_t e, got_e;
    bit ok;
    send_beat(64'd5, 1'b0);
    send_beat(64'd7, 1'b0);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_p     = 64'd9;
    bus.in_last  = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_in_ready: got %0b required 1", bus.in_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_sum !== 72'h0 || bus.out_count !== 8'h0) begin
      failures++;
      $display("FAIL clear_zero: sum=%0d count=%0d required 0/0", bus.out_sum, bus.out_count);
    end
    e.sum = 72'd5; e.count = 8'd2; e.ovf = 1'b0;
    sb.push_back(e);
    send_beat(64'd2, 1'b0);
    send_beat(64'd3, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(ok);
    got_e = sb.pop_front();
    checks++;
    if (!ok || bus.out_sum !== got_e.sum || bus.out_count !== got_e.count) begin
      failures++;
      $display("FAIL clear_result: sum=%0d count=%0d required %0d/%0d",
               bus.out_sum, bus.out_count, got_e.sum, got_e.count);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    exp_t e, got_e;
    bit ok;
    e.sum = 72'h1; e.count = 8'd2; e.ovf = 1'b1;
    sb64.push_back(e);
    bus64.out_ready = 1'b1;
    send_beat64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat64(64'h2, 1'b1);
    bus64.in_valid = 1'b0;
    wait_result64(ok);
    got_e = sb64.pop_front();
    checks++;
    if (!ok || {8'h0, bus64.out_sum} !== got_e.sum || bus64.out_ovf !== got_e.ovf || bus64.out_count !== got_e.count) begin
      failures++;
      $display("FAIL overflow_wrap: sum=%0h ovf=%0b count=%0d required %0h/%0b/%0d",
               bus64.out_sum, bus64.out_ovf, bus64.out_count, got_e.sum, got_e.ovf, got_e.count);
    end
    @(negedge clk);
    e.sum = 72'h3; e.count = 8'd1; e.ovf = 1'b0;
    sb64.push_back(e);
    send_beat64(64'h3, 1'b1);
    bus64.in_valid = 1'b0;
    wait_result64(ok);
    got_e = sb64.pop_front();
    checks++;
    if (!ok || {8'h0, bus64.out_sum} !== got_e.sum || bus64.out_ovf !== got_e.ovf) begin
      failures++;
      $display("FAIL overflow_next: sum=%0h ovf=%0b required %0h/%0b",
               bus64.out_sum, bus64.out_ovf, got_e.sum, got_e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset_hold();
    bit ok;
    bus.out_ready = 1'b0;
    send_beat(64'h55, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(ok);
    checks++;
    if (!ok || bus.out_sum !== 72'h55) begin
      failures++;
      $display("FAIL async_pre_hold: valid=%0b sum=%0h required 1/55", bus.out_valid, bus.out_sum);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 72'h0 || bus.out_count !== 8'h0) begin
      failures++;
      $display("FAIL async_reset_now: valid=%0b sum=%0h count=%0d required 0/0/0",
               bus.out_valid, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL async_no_result: out_valid=%0b required 0 at cycle %0d", bus.out_valid, i);
      end
    end
    checks++;
    if (sb.size() != 0 || sb64.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: pending=%0d required 0", sb.size() + sb64.size());
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_p        = '0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.in_p      = '0;
    bus64.in_last   = 1'b0;
    bus64.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_early_last();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_overflow();
    test_async_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
